// File: rtl/pipe_pkg.sv
// Shared types and default widths for pipeline stage instances.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam int unsigned DefaultDataW     = 32;
    localparam int unsigned DefaultStallCntW = 16;

endpackage

// File: rtl/sat_counter.sv
// Enable-driven saturating up-counter, falling-edge clocked to match the stage it serves.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stage_skid.sv
// Valid/ready pipeline register with a 1-entry skid buffer, flush and a stall counter.
module pipeline_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = DefaultDataW,
    parameter logic [DATA_W-1:0] FLUSH_VALUE = '0,
    parameter int unsigned       STALL_CNT_W = DefaultStallCntW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_count
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              acc, take;

    assign acc  = in_valid && in_ready_q;
    assign take = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A same-edge take has already completed downstream; the accept is dropped.
            state_d = ST_EMPTY;
            main_d  = FLUSH_VALUE;
            skid_d  = FLUSH_VALUE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && take) begin
                        main_d = in_data;
                    end else if (acc) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (take) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (take) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (out_valid_q && !out_ready),
        .count_o (stall_count)
    );

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;

endmodule
